// File: rtl/elbeth_hazard_pkg.sv
// Shared definitions for the ELBETH pipeline hazard controller:
// FSM state encodings and the hard-wired zero register index.
package elbeth_hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_DMEM_WAIT  = 2'd1,
        HZ_TRAP_REDIR = 2'd2
    } hz_state_e;

    // x0 is never a real producer, so it can never create a load-use hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/elbeth_hazard_watchdog.sv
// Data-memory wait watchdog: counts consecutive enabled cycles and emits a
// registered one-cycle expiry pulse when the count reaches STALL_TIMEOUT.
// The count restarts from zero after expiry and whenever counting is disabled.
module elbeth_hazard_watchdog #(
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    // Next count: saturating increment while enabled, clear on expiry or idle.
    always_comb begin
        cnt_d    = '0;
        expire_d = 1'b0;
        if (count_en_i) begin
            if (cnt_q == LAST_CNT) begin
                expire_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Counter and expiry pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/elbeth_hazard_unit.sv
// ELBETH five-stage core hazard controller. Produces zero-latency stall and
// flush controls from the current FSM state and pipeline conditions, tracks
// multi-cycle data-memory waits and the post-trap redirect cycle, and runs a
// watchdog on data-memory waits.
// Optional cycle counters: define ELBETH_HAZARD_PERF_EN to build them;
// otherwise the perf ports read as constant zero.
module elbeth_hazard_unit
    import elbeth_hazard_pkg::*;
#(
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  exs_rd_addr,
    input  logic        exs_ctrl_reg_w,
    input  logic        exs_ctrl_mem_en,
    input  logic        exs_ctrl_mem_rw,
    input  logic        exs_branch_taken,
    input  logic        mem_ctrl_mem_en,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    input  logic        wb_trap,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idexs_stall,
    output logic        idexs_flush,
    output logic        exsmem_stall,
    output logic        exsmem_flush,
    output logic        stall_timeout,
    output logic [1:0]  hz_state,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_cycles
);

    hz_state_e state_q, state_d;

    logic load_use;
    logic dwait;
    logic wd_count_en;

    logic pc_stall_c, ifid_stall_c, ifid_flush_c;
    logic idexs_stall_c, idexs_flush_c, exsmem_stall_c, exsmem_flush_c;

    // Hazard condition decode.
    always_comb begin
        load_use = exs_ctrl_mem_en && !exs_ctrl_mem_rw && exs_ctrl_reg_w &&
                   (exs_rd_addr != REG_ZERO) &&
                   ((id_rs1_used && (id_rs1_addr == exs_rd_addr)) ||
                    (id_rs2_used && (id_rs2_addr == exs_rd_addr)));
        dwait    = mem_ctrl_mem_en && !dmem_ready;
    end

    // Prioritised stall/flush selection and FSM next state.
    always_comb begin
        state_d        = state_q;
        pc_stall_c     = 1'b0;
        ifid_stall_c   = 1'b0;
        ifid_flush_c   = 1'b0;
        idexs_stall_c  = 1'b0;
        idexs_flush_c  = 1'b0;
        exsmem_stall_c = 1'b0;
        exsmem_flush_c = 1'b0;
        if (wb_trap) begin
            // A committing trap squashes everything younger, even mid-wait.
            ifid_flush_c   = 1'b1;
            idexs_flush_c  = 1'b1;
            exsmem_flush_c = 1'b1;
            state_d        = HZ_TRAP_REDIR;
        end else if (state_q == HZ_TRAP_REDIR) begin
            // The fetch in flight during the trap came from the old PC.
            ifid_flush_c = 1'b1;
            state_d      = HZ_RUN;
        end else if (dwait) begin
            pc_stall_c     = 1'b1;
            ifid_stall_c   = 1'b1;
            idexs_stall_c  = 1'b1;
            exsmem_stall_c = 1'b1;
            state_d        = HZ_DMEM_WAIT;
        end else begin
            state_d = HZ_RUN;
            if (exs_branch_taken) begin
                // The ID instruction is squashed, so a load-use stall is moot.
                ifid_flush_c  = 1'b1;
                idexs_flush_c = 1'b1;
            end else if (load_use) begin
                pc_stall_c    = 1'b1;
                ifid_stall_c  = 1'b1;
                idexs_flush_c = 1'b1;
            end else if (!imem_ready) begin
                pc_stall_c   = 1'b1;
                ifid_flush_c = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Only cycles that stay in the wait count; any other cycle restarts it.
    assign wd_count_en = (state_q == HZ_DMEM_WAIT) && dwait && !wb_trap;

    elbeth_hazard_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_en_i (wd_count_en),
        .expire_o   (stall_timeout)
    );

    // Controls are held inactive for the whole reset window.
    assign pc_stall     = rst_n && pc_stall_c;
    assign ifid_stall   = rst_n && ifid_stall_c;
    assign ifid_flush   = rst_n && ifid_flush_c;
    assign idexs_stall  = rst_n && idexs_stall_c;
    assign idexs_flush  = rst_n && idexs_flush_c;
    assign exsmem_stall = rst_n && exsmem_stall_c;
    assign exsmem_flush = rst_n && exsmem_flush_c;
    assign hz_state     = state_q;

`ifdef ELBETH_HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;
    logic        any_flush;

    assign any_flush = ifid_flush || idexs_flush || exsmem_flush;

    // Free-running wrap-around cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, pc_stall};
            perf_flush_q <= perf_flush_q + {31'd0, any_flush};
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cycles = perf_flush_q;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_elbeth_hazard_unit.sv
// Self-checking bench for elbeth_hazard_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model. Perf expectations follow ELBETH_HAZARD_PERF_EN.
module tb_elbeth_hazard_unit;

    localparam int TO = 4;

    // Output vector order: {pc_s, ifid_s, ifid_f, idexs_s, idexs_f, exsmem_s, exsmem_f}
    localparam logic [6:0] M_PC  = 7'b1000000;
    localparam logic [6:0] M_IFS = 7'b0100000;
    localparam logic [6:0] M_IFF = 7'b0010000;
    localparam logic [6:0] M_IDS = 7'b0001000;
    localparam logic [6:0] M_IDF = 7'b0000100;
    localparam logic [6:0] M_EMS = 7'b0000010;
    localparam logic [6:0] M_EMF = 7'b0000001;
    localparam logic [6:0] STALL4 = M_PC | M_IFS | M_IDS | M_EMS;
    localparam logic [6:0] FLUSH3 = M_IFF | M_IDF | M_EMF;

    logic        clk, rst_n;
    logic [4:0]  id_rs1_addr, id_rs2_addr, exs_rd_addr;
    logic        id_rs1_used, id_rs2_used, exs_ctrl_reg_w, exs_ctrl_mem_en, exs_ctrl_mem_rw;
    logic        exs_branch_taken, mem_ctrl_mem_en, dmem_ready, imem_ready, wb_trap;
    logic        pc_stall, ifid_stall, ifid_flush, idexs_stall, idexs_flush;
    logic        exsmem_stall, exsmem_flush, stall_timeout;
    logic [1:0]  hz_state;
    logic [31:0] perf_stall_cycles, perf_flush_cycles;
    logic [6:0]  dut_vec;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model state
    int          m_state;
    int          m_wait_run;
    bit          m_to;
    logic [31:0] m_ps, m_pf;

    elbeth_hazard_unit #(.STALL_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .id_rs1_used       (id_rs1_used),
        .id_rs2_used       (id_rs2_used),
        .exs_rd_addr       (exs_rd_addr),
        .exs_ctrl_reg_w    (exs_ctrl_reg_w),
        .exs_ctrl_mem_en   (exs_ctrl_mem_en),
        .exs_ctrl_mem_rw   (exs_ctrl_mem_rw),
        .exs_branch_taken  (exs_branch_taken),
        .mem_ctrl_mem_en   (mem_ctrl_mem_en),
        .dmem_ready        (dmem_ready),
        .imem_ready        (imem_ready),
        .wb_trap           (wb_trap),
        .pc_stall          (pc_stall),
        .ifid_stall        (ifid_stall),
        .ifid_flush        (ifid_flush),
        .idexs_stall       (idexs_stall),
        .idexs_flush       (idexs_flush),
        .exsmem_stall      (exsmem_stall),
        .exsmem_flush      (exsmem_flush),
        .stall_timeout     (stall_timeout),
        .hz_state          (hz_state),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cycles (perf_flush_cycles)
    );

    assign dut_vec = {pc_stall, ifid_stall, ifid_flush, idexs_stall, idexs_flush,
                      exsmem_stall, exsmem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_wait_run = 0;
        m_to       = 1'b0;
        m_ps       = 32'd0;
        m_pf       = 32'd0;
    endtask

    task automatic idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        exs_rd_addr = 5'd0; exs_ctrl_reg_w = 1'b0; exs_ctrl_mem_en = 1'b0; exs_ctrl_mem_rw = 1'b0;
        exs_branch_taken = 1'b0; mem_ctrl_mem_en = 1'b0; dmem_ready = 1'b1;
        imem_ready = 1'b1; wb_trap = 1'b0;
    endtask

    function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef ELBETH_HAZARD_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Compare the current cycle against the model, then advance one clock.
    task automatic tick();
        logic [6:0] e;
        int         nxt;
        bit         lu, dw;
        lu = exs_ctrl_mem_en && !exs_ctrl_mem_rw && exs_ctrl_reg_w && exs_rd_addr != 5'd0 &&
             ((id_rs1_used && id_rs1_addr == exs_rd_addr) ||
              (id_rs2_used && id_rs2_addr == exs_rd_addr));
        dw = mem_ctrl_mem_en && !dmem_ready;
        e   = 7'd0;
        nxt = 0;
        if (wb_trap)               begin e = FLUSH3; nxt = 2; end
        else if (m_state == 2)     begin e = M_IFF; end
        else if (dw)               begin e = STALL4; nxt = 1; end
        else if (exs_branch_taken) begin e = M_IFF | M_IDF; end
        else if (lu)               begin e = M_PC | M_IFS | M_IDF; end
        else if (!imem_ready)      begin e = M_PC | M_IFF; end

        chk("outs", {25'd0, dut_vec}, {25'd0, e});
        chk("hz_state", {30'd0, hz_state}, m_state);
        chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
        chk("perf_stall", perf_stall_cycles, exp_perf(m_ps));
        chk("perf_flush", perf_flush_cycles, exp_perf(m_pf));
        $display("cyc=%0d st=%0d outs=%b to=%b exp_outs=%b", cyc, hz_state, dut_vec, stall_timeout, e);

        // Watchdog: length of the current run of wait cycles that stay waiting.
        m_to = 1'b0;
        if (!wb_trap && m_state == 1 && dw) begin
            m_wait_run++;
            if (m_wait_run == TO) begin
                m_to       = 1'b1;
                m_wait_run = 0;
            end
        end else begin
            m_wait_run = 0;
        end
        m_ps += (e & M_PC) != 0 ? 32'd1 : 32'd0;
        m_pf += (e & FLUSH3) != 0 ? 32'd1 : 32'd0;
        m_state = nxt;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Literal (hand-computed) checks of the current cycle.
    task automatic lit(input string name, input logic [6:0] exp_outs, input logic [1:0] exp_st);
        chk({name, "_outs"}, {25'd0, dut_vec}, {25'd0, exp_outs});
        chk({name, "_st"}, {30'd0, hz_state}, {30'd0, exp_st});
    endtask

    int burst;

    initial begin
        model_reset();
        idle();
        rst_n = 1'b0;
        mem_ctrl_mem_en = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0;
        #3;
        lit("reset", 7'd0, 2'd0);
        chk("reset_to", {31'd0, stall_timeout}, 32'd0);
        chk("reset_perf", perf_stall_cycles, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        #1;

        // Three-cycle data-memory wait, then release.
        mem_ctrl_mem_en = 1'b1; dmem_ready = 1'b0; #1;
        lit("dw1", STALL4, 2'd0); tick();
        lit("dw2", STALL4, 2'd1); tick();
        lit("dw3", STALL4, 2'd1); tick();
        dmem_ready = 1'b1; #1;
        lit("dw_exit", 7'd0, 2'd1); tick();
        idle(); #1;
        lit("dw_after", 7'd0, 2'd0);
        chk("perf_stall_lit", perf_stall_cycles, exp_perf(32'd3));
        tick();

        // Load-use on rs2, then the bubble, then the rd=0 variant.
        exs_rd_addr = 5'd5; exs_ctrl_mem_en = 1'b1; exs_ctrl_reg_w = 1'b1;
        id_rs2_addr = 5'd5; id_rs2_used = 1'b1; #1;
        lit("load_use", M_PC | M_IFS | M_IDF, 2'd0); tick();
        idle(); id_rs2_addr = 5'd5; id_rs2_used = 1'b1; #1;
        lit("lu_bubble", 7'd0, 2'd0); tick();
        exs_rd_addr = 5'd0; exs_ctrl_mem_en = 1'b1; exs_ctrl_reg_w = 1'b1;
        id_rs2_addr = 5'd0; #1;
        lit("lu_rd0", 7'd0, 2'd0); tick();

        // Branch beats load-use.
        exs_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_rs1_used = 1'b1; exs_branch_taken = 1'b1; #1;
        lit("br_lu", M_IFF | M_IDF, 2'd0); tick();
        idle(); imem_ready = 1'b0; #1;
        lit("imem_wait", M_PC | M_IFF, 2'd0); tick();

        // Watchdog expiry, then trap answer.
        idle(); mem_ctrl_mem_en = 1'b1; dmem_ready = 1'b0; #1;
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("to_low", {31'd0, stall_timeout}, 32'd0);
            tick();
        end
        chk("to_pulse", {31'd0, stall_timeout}, 32'd1);
        lit("to_pulse", STALL4, 2'd1);
        tick();
        chk("to_one_cycle", {31'd0, stall_timeout}, 32'd0);
        wb_trap = 1'b1; #1;
        lit("to_trap", FLUSH3, 2'd1); tick();
        idle(); #1;
        lit("to_redir", M_IFF, 2'd2); tick();
        lit("to_run", 7'd0, 2'd0); tick();

        // Trap during a wait; redirect wins over a still-pending wait.
        mem_ctrl_mem_en = 1'b1; dmem_ready = 1'b0; #1;
        tick(); tick();
        wb_trap = 1'b1; #1;
        lit("wait_trap", FLUSH3, 2'd1); tick();
        wb_trap = 1'b0; #1;
        lit("wait_redir", M_IFF, 2'd2); tick();
        idle(); #1;
        lit("wait_run", 7'd0, 2'd0); tick();

        // Randomized traffic, with occasional long data waits.
        burst = 0;
        for (int n = 0; n < 800; n++) begin
            id_rs1_addr      = 5'($urandom_range(0, 3));
            id_rs2_addr      = 5'($urandom_range(0, 3));
            exs_rd_addr      = 5'($urandom_range(0, 3));
            id_rs1_used      = 1'($urandom_range(0, 1));
            id_rs2_used      = 1'($urandom_range(0, 1));
            exs_ctrl_reg_w   = ($urandom_range(0, 3) != 0);
            exs_ctrl_mem_en  = 1'($urandom_range(0, 1));
            exs_ctrl_mem_rw  = ($urandom_range(0, 3) == 0);
            exs_branch_taken = ($urandom_range(0, 6) == 0);
            imem_ready       = ($urandom_range(0, 4) != 0);
            wb_trap          = ($urandom_range(0, 24) == 0);
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(3, 9);
            if (burst > 0) begin
                mem_ctrl_mem_en = 1'b1; dmem_ready = 1'b0; burst--;
            end else begin
                mem_ctrl_mem_en = 1'($urandom_range(0, 1));
                dmem_ready      = ($urandom_range(0, 2) != 0);
            end
            #1;
            tick();
        end

        // Asynchronous reset in the middle of a wait.
        idle(); mem_ctrl_mem_en = 1'b1; dmem_ready = 1'b0; #1;
        tick(); tick();
        rst_n = 1'b0; #1;
        lit("async_rst", 7'd0, 2'd0);
        chk("async_rst_perf_s", perf_stall_cycles, 32'd0);
        chk("async_rst_perf_f", perf_flush_cycles, 32'd0);
        chk("async_rst_to", {31'd0, stall_timeout}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; idle(); #1;
        lit("post_rst", 7'd0, 2'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
